// File: rtl/bank_account_server_if.sv
// Request/response bundle between an ATM front end and the bank account server.
// The server side uses the slave modport; the ATM (or testbench) uses master.
interface bank_account_server_if #(
    parameter int balance_width = 20
);

    logic                     req_valid;
    logic                     req_ready;
    logic [2:0]               req_cmd;
    logic [1:0]               req_id;
    logic [15:0]              req_psw;
    logic [balance_width-1:0] req_value;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [2:0]               rsp_status;
    logic [balance_width-1:0] rsp_balance;
    logic                     session_active;

    modport master (
        output req_valid,
        output req_cmd,
        output req_id,
        output req_psw,
        output req_value,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_status,
        input  rsp_balance,
        input  session_active
    );

    modport slave (
        input  req_valid,
        input  req_cmd,
        input  req_id,
        input  req_psw,
        input  req_value,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_status,
        output rsp_balance,
        output session_active
    );

endinterface

// File: rtl/bank_account_server.sv
// Bank account server: a small table of accounts (balance, password, failed
// login counter) behind a request/response handshake. One request is handled
// at a time through IDLE -> LOOKUP -> EXEC -> RESP. A single login session can
// be open; money commands act on the session account only.
module bank_account_server #(
    parameter int          balance_width = 20,
    parameter int          NUM_ACCOUNTS  = 4,
    parameter int          INIT_BALANCE  = 1000,
    parameter logic [15:0] PSW_BASE      = 16'h1234
) (
    input  logic                 clk,
    input  logic                 rst,
    bank_account_server_if.slave bus
);

    localparam int BW = balance_width;

    // FSM encoding
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    // Command codes
    localparam logic [2:0] CMD_AUTH     = 3'd0;
    localparam logic [2:0] CMD_WITHDRAW = 3'd1;
    localparam logic [2:0] CMD_DEPOSIT  = 3'd2;
    localparam logic [2:0] CMD_BALANCE  = 3'd3;
    localparam logic [2:0] CMD_LOGOUT   = 3'd4;

    // Response status codes
    localparam logic [2:0] ST_OK           = 3'd0;
    localparam logic [2:0] ST_BAD_ID       = 3'd1;
    localparam logic [2:0] ST_BAD_PSW      = 3'd2;
    localparam logic [2:0] ST_LOCKED       = 3'd3;
    localparam logic [2:0] ST_INSUFFICIENT = 3'd4;
    localparam logic [2:0] ST_OVERFLOW     = 3'd5;
    localparam logic [2:0] ST_NO_SESSION   = 3'd6;
    localparam logic [2:0] ST_BAD_CMD      = 3'd7;

    localparam logic [1:0] FAIL_LIMIT = 2'd3;
    localparam logic [2:0] NUM_ACC3   = 3'(NUM_ACCOUNTS);
    localparam logic [BW-1:0] INIT_BAL = BW'(INIT_BALANCE);

    // FSM and captured request
    logic [1:0]    r_state;
    logic [2:0]    r_cmd;
    logic [1:0]    r_id;
    logic [15:0]   r_psw;
    logic [BW-1:0] r_value;

    // Snapshot of the addressed account, taken in LOOKUP
    logic [1:0]    r_target;
    logic          r_idValid;
    logic [BW-1:0] r_curBal;
    logic [1:0]    r_curFail;
    logic [15:0]   r_curPsw;

    // Account table
    logic [BW-1:0] r_bal     [NUM_ACCOUNTS];
    logic [1:0]    r_fail    [NUM_ACCOUNTS];
    logic [15:0]   r_pswTab  [NUM_ACCOUNTS];

    // Session and response registers
    logic          r_sessActive;
    logic [1:0]    r_sessId;
    logic          r_rspValid;
    logic [2:0]    r_rspStatus;
    logic [BW-1:0] r_rspBal;

    // Lookup-stage wires
    logic [1:0]    w_lookupIdx;
    logic          w_lookupValid;
    logic [BW-1:0] w_selBal;
    logic [1:0]    w_selFail;
    logic [15:0]   w_selPsw;

    // Execute-stage wires
    logic [BW:0]   w_sum;
    logic [BW-1:0] w_newBal;
    logic [1:0]    w_newFail;
    logic          w_wrBal;
    logic          w_wrFail;
    logic [2:0]    w_status;
    logic          w_sessOpen;
    logic [1:0]    w_sessId;
    logic [BW-1:0] w_rspBal;

    assign bus.req_ready      = (r_state == S_IDLE);
    assign bus.rsp_valid      = r_rspValid;
    assign bus.rsp_status     = r_rspStatus;
    assign bus.rsp_balance    = r_rspBal;
    assign bus.session_active = r_sessActive;

    // AUTH addresses the requested id; everything else works on the session account
    assign w_lookupIdx   = (r_cmd == CMD_AUTH) ? r_id : r_sessId;
    assign w_lookupValid = (r_cmd == CMD_AUTH) ? ({1'b0, r_id} < NUM_ACC3) : 1'b1;

    // Read mux over the account table; an out-of-range id reads as zeros
    always_comb begin
        w_selBal  = '0;
        w_selFail = '0;
        w_selPsw  = '0;
        for (int k = 0; k < NUM_ACCOUNTS; k++) begin
            if (w_lookupIdx == 2'(k)) begin
                w_selBal  = r_bal[k];
                w_selFail = r_fail[k];
                w_selPsw  = r_pswTab[k];
            end
        end
    end

    assign w_sum = {1'b0, r_curBal} + {1'b0, r_value};

    // Command semantics: next account/session state and the response status
    always_comb begin
        w_newBal   = r_curBal;
        w_newFail  = r_curFail;
        w_wrBal    = 1'b0;
        w_wrFail   = 1'b0;
        w_status   = ST_OK;
        w_sessOpen = r_sessActive;
        w_sessId   = r_sessId;
        case (r_cmd)
            CMD_AUTH: begin
                w_sessOpen = 1'b0;
                if (!r_idValid) begin
                    w_status = ST_BAD_ID;
                end else if (r_curFail == FAIL_LIMIT) begin
                    w_status = ST_LOCKED;
                end else if (r_psw != r_curPsw) begin
                    w_newFail = r_curFail + 2'd1;
                    w_wrFail  = 1'b1;
                    w_status  = ST_BAD_PSW;
                end else begin
                    w_newFail  = 2'd0;
                    w_wrFail   = 1'b1;
                    w_sessOpen = 1'b1;
                    w_sessId   = r_target;
                    w_status   = ST_OK;
                end
            end
            CMD_WITHDRAW: begin
                if (!r_sessActive) begin
                    w_status = ST_NO_SESSION;
                end else if (r_value > r_curBal) begin
                    w_status = ST_INSUFFICIENT;
                end else begin
                    w_newBal = r_curBal - r_value;
                    w_wrBal  = 1'b1;
                end
            end
            CMD_DEPOSIT: begin
                if (!r_sessActive) begin
                    w_status = ST_NO_SESSION;
                end else if (w_sum[BW]) begin
                    w_status = ST_OVERFLOW;
                end else begin
                    w_newBal = w_sum[BW-1:0];
                    w_wrBal  = 1'b1;
                end
            end
            CMD_BALANCE: begin
                if (!r_sessActive) begin
                    w_status = ST_NO_SESSION;
                end
            end
            CMD_LOGOUT: begin
                w_sessOpen = 1'b0;
            end
            default: begin
                w_status = ST_BAD_CMD;
            end
        endcase
    end

    // Reported balance is the session account after the command, 0 with no session
    assign w_rspBal = w_sessOpen ? w_newBal : '0;

    // Request FSM: accept in IDLE, walk through LOOKUP/EXEC, hold RESP until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cmd      <= '0;
            r_id       <= '0;
            r_psw      <= '0;
            r_value    <= '0;
            r_rspValid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_cmd   <= bus.req_cmd;
                        r_id    <= bus.req_id;
                        r_psw   <= bus.req_psw;
                        r_value <= bus.req_value;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (!r_rspValid) begin
                        r_rspValid <= 1'b1;
                    end else if (bus.rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Snapshot the target account so EXEC works from registered values
    always_ff @(posedge clk) begin
        if (rst) begin
            r_target  <= '0;
            r_idValid <= 1'b0;
            r_curBal  <= '0;
            r_curFail <= '0;
            r_curPsw  <= '0;
        end else if (r_state == S_LOOKUP) begin
            r_target  <= w_lookupIdx;
            r_idValid <= w_lookupValid;
            r_curBal  <= w_selBal;
            r_curFail <= w_selFail;
            r_curPsw  <= w_selPsw;
        end
    end

    // Commit session state and the response fields at the end of EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sessActive <= 1'b0;
            r_sessId     <= '0;
            r_rspStatus  <= '0;
            r_rspBal     <= '0;
        end else if (r_state == S_EXEC) begin
            r_sessActive <= w_sessOpen;
            r_sessId     <= w_sessId;
            r_rspStatus  <= w_status;
            r_rspBal     <= w_rspBal;
        end
    end

    // Account table: reloaded on reset, written only for the addressed account in EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_ACCOUNTS; k++) begin
                r_bal[k]    <= INIT_BAL;
                r_fail[k]   <= 2'd0;
                r_pswTab[k] <= PSW_BASE + 16'(k);
            end
        end else if (r_state == S_EXEC && r_idValid) begin
            for (int k = 0; k < NUM_ACCOUNTS; k++) begin
                if (r_target == 2'(k)) begin
                    if (w_wrBal) begin
                        r_bal[k] <= w_newBal;
                    end
                    if (w_wrFail) begin
                        r_fail[k] <= w_newFail;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bank_account_server.sv
// Directed testbench for bank_account_server (3 accounts). Expected responses
// are queued when a request is issued and popped when the server answers.
module tb_bank_account_server;

    localparam int BW = 20;

    localparam logic [2:0] CMD_AUTH     = 3'd0;
    localparam logic [2:0] CMD_WITHDRAW = 3'd1;
    localparam logic [2:0] CMD_DEPOSIT  = 3'd2;
    localparam logic [2:0] CMD_BALANCE  = 3'd3;
    localparam logic [2:0] CMD_LOGOUT   = 3'd4;

    localparam logic [2:0] ST_OK           = 3'd0;
    localparam logic [2:0] ST_BAD_ID       = 3'd1;
    localparam logic [2:0] ST_BAD_PSW      = 3'd2;
    localparam logic [2:0] ST_LOCKED       = 3'd3;
    localparam logic [2:0] ST_INSUFFICIENT = 3'd4;
    localparam logic [2:0] ST_OVERFLOW     = 3'd5;
    localparam logic [2:0] ST_NO_SESSION   = 3'd6;
    localparam logic [2:0] ST_BAD_CMD      = 3'd7;

    localparam logic [BW-1:0] MAX_BAL = 20'd1048575;

    typedef struct packed {
        logic [2:0]    status;
        logic [BW-1:0] balance;
        logic          sess;
    } expT;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    expT  expQ[$];

    bank_account_server_if #(.balance_width(BW)) bus ();

    bank_account_server #(
        .balance_width (BW),
        .NUM_ACCOUNTS  (3),
        .INIT_BALANCE  (1000),
        .PSW_BASE      (16'h1234)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Watchdog so a stuck handshake can never hang the run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no end of test, required completion");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input expT e);
        checkValue({tag, ".status"},  32'(bus.rsp_status),     32'(e.status));
        checkValue({tag, ".balance"}, 32'(bus.rsp_balance),    32'(e.balance));
        checkValue({tag, ".session"}, 32'(bus.session_active), 32'(e.sess));
    endtask

    task automatic applyStimulus(input string tag, input logic [2:0] cmd, input logic [1:0] id,
                                 input logic [15:0] psw, input logic [BW-1:0] value,
                                 input logic [2:0] expStatus, input logic [BW-1:0] expBal,
                                 input logic expSess, input int stall);
        int  n;
        expT e;
        e.status  = expStatus;
        e.balance = expBal;
        e.sess    = expSess;
        expQ.push_back(e);

        @(negedge clk);
        bus.req_cmd   = cmd;
        bus.req_id    = id;
        bus.req_psw   = psw;
        bus.req_value = value;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkValue({tag, ".reqReady"}, 32'(bus.req_ready), 32'd1);
        if (!bus.req_ready) begin
            bus.req_valid = 1'b0;
            expQ.delete(expQ.size() - 1);
            return;
        end

        @(posedge clk);
        n = 0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_cmd   = 3'($urandom);
        bus.req_id    = 2'($urandom);
        bus.req_psw   = 16'($urandom);
        bus.req_value = BW'($urandom);
        while (!bus.rsp_valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        checkValue({tag, ".latency"}, 32'(n), 32'd3);
        if (!bus.rsp_valid) begin
            expQ.delete(expQ.size() - 1);
            return;
        end

        if (expQ.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL %s.scoreboard: observed empty queue, required one entry", tag);
        end else begin
            e = expQ.pop_front();
            checkOutput(tag, e);
        end

        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checkValue({tag, ".stallValid"},  32'(bus.rsp_valid),   32'd1);
            checkValue({tag, ".stallStatus"}, 32'(bus.rsp_status),  32'(e.status));
            checkValue({tag, ".stallBal"},    32'(bus.rsp_balance), 32'(e.balance));
            checkValue({tag, ".stallReady"},  32'(bus.req_ready),   32'd0);
        end

        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checkValue({tag, ".rspDone"},   32'(bus.rsp_valid), 32'd0);
        checkValue({tag, ".backIdle"},  32'(bus.req_ready), 32'd1);
    endtask

    // Directed test sequence
    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_cmd   = '0;
        bus.req_id    = '0;
        bus.req_psw   = '0;
        bus.req_value = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkValue("reset.reqReady",  32'(bus.req_ready),      32'd1);
        checkValue("reset.rspValid",  32'(bus.rsp_valid),      32'd0);
        checkValue("reset.rspStatus", 32'(bus.rsp_status),     32'd0);
        checkValue("reset.rspBal",    32'(bus.rsp_balance),    32'd0);
        checkValue("reset.session",   32'(bus.session_active), 32'd0);

        // Login and money movement on account 1, including the width boundaries
        applyStimulus("auth1",      CMD_AUTH,     2'd1, 16'h1235, 20'd0,    ST_OK,           20'd1000, 1'b1, 0);
        applyStimulus("wdAll",      CMD_WITHDRAW, 2'd0, 16'h0,    20'd1000, ST_OK,           20'd0,    1'b1, 0);
        applyStimulus("wdEmpty",    CMD_WITHDRAW, 2'd0, 16'h0,    20'd1,    ST_INSUFFICIENT, 20'd0,    1'b1, 0);
        applyStimulus("depMax",     CMD_DEPOSIT,  2'd0, 16'h0,    MAX_BAL,  ST_OK,           MAX_BAL,  1'b1, 0);
        applyStimulus("depOvf",     CMD_DEPOSIT,  2'd0, 16'h0,    20'd1,    ST_OVERFLOW,     MAX_BAL,  1'b1, 0);
        applyStimulus("depZero",    CMD_DEPOSIT,  2'd0, 16'h0,    20'd0,    ST_OK,           MAX_BAL,  1'b1, 0);
        applyStimulus("wdZero",     CMD_WITHDRAW, 2'd0, 16'h0,    20'd0,    ST_OK,           MAX_BAL,  1'b1, 0);
        applyStimulus("balance1",   CMD_BALANCE,  2'd0, 16'h0,    20'd0,    ST_OK,           MAX_BAL,  1'b1, 0);

        // Three bad passwords lock account 2, and AUTH drops the open session
        applyStimulus("badPsw1",    CMD_AUTH,     2'd2, 16'h0000, 20'd0,    ST_BAD_PSW,      20'd0,    1'b0, 0);
        applyStimulus("badPsw2",    CMD_AUTH,     2'd2, 16'h0000, 20'd0,    ST_BAD_PSW,      20'd0,    1'b0, 0);
        applyStimulus("badPsw3",    CMD_AUTH,     2'd2, 16'h0000, 20'd0,    ST_BAD_PSW,      20'd0,    1'b0, 0);
        applyStimulus("locked",     CMD_AUTH,     2'd2, 16'h1236, 20'd0,    ST_LOCKED,       20'd0,    1'b0, 0);

        // No-session commands, bad id, illegal command, idle logout
        applyStimulus("noSessBal",  CMD_BALANCE,  2'd0, 16'h0,    20'd0,    ST_NO_SESSION,   20'd0,    1'b0, 0);
        applyStimulus("noSessWd",   CMD_WITHDRAW, 2'd0, 16'h0,    20'd5,    ST_NO_SESSION,   20'd0,    1'b0, 0);
        applyStimulus("badId",      CMD_AUTH,     2'd3, 16'h1237, 20'd0,    ST_BAD_ID,       20'd0,    1'b0, 0);
        applyStimulus("badCmd",     3'd6,         2'd0, 16'h0,    20'd0,    ST_BAD_CMD,      20'd0,    1'b0, 0);
        applyStimulus("idleLogout", CMD_LOGOUT,   2'd0, 16'h0,    20'd0,    ST_OK,           20'd0,    1'b0, 0);

        // Account 1 kept its balance; logout closes the session
        applyStimulus("reauth1",    CMD_AUTH,     2'd1, 16'h1235, 20'd0,    ST_OK,           MAX_BAL,  1'b1, 0);
        applyStimulus("logout",     CMD_LOGOUT,   2'd0, 16'h0,    20'd0,    ST_OK,           20'd0,    1'b0, 0);
        applyStimulus("postLogout", CMD_BALANCE,  2'd0, 16'h0,    20'd0,    ST_NO_SESSION,   20'd0,    1'b0, 0);

        // A good password clears the fail count, so only consecutive misses lock
        applyStimulus("acc0Bad1",   CMD_AUTH,     2'd0, 16'h9999, 20'd0,    ST_BAD_PSW,      20'd0,    1'b0, 0);
        applyStimulus("acc0Bad2",   CMD_AUTH,     2'd0, 16'h9999, 20'd0,    ST_BAD_PSW,      20'd0,    1'b0, 0);
        applyStimulus("acc0Good",   CMD_AUTH,     2'd0, 16'h1234, 20'd0,    ST_OK,           20'd1000, 1'b1, 0);
        applyStimulus("acc0Bad3",   CMD_AUTH,     2'd0, 16'h9999, 20'd0,    ST_BAD_PSW,      20'd0,    1'b0, 0);
        applyStimulus("acc0Bad4",   CMD_AUTH,     2'd0, 16'h9999, 20'd0,    ST_BAD_PSW,      20'd0,    1'b0, 0);
        applyStimulus("acc0Good2",  CMD_AUTH,     2'd0, 16'h1234, 20'd0,    ST_OK,           20'd1000, 1'b1, 0);

        // Response back-pressure: hold rsp_ready low for 5 cycles
        applyStimulus("stall",      CMD_BALANCE,  2'd0, 16'h0,    20'd0,    ST_OK,           20'd1000, 1'b1, 5);

        // Reset while a WITHDRAW is in EXEC: no response, everything reloaded
        @(negedge clk);
        bus.req_cmd   = CMD_WITHDRAW;
        bus.req_value = 20'd100;
        bus.req_valid = 1'b1;
        checkValue("rstExec.reqReady", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkValue("rstExec.session",  32'(bus.session_active), 32'd0);
        checkValue("rstExec.reqReady2",32'(bus.req_ready),      32'd1);
        checkValue("rstExec.rspBal",   32'(bus.rsp_balance),    32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkValue("rstExec.noRsp", 32'(bus.rsp_valid), 32'd0);
        end

        applyStimulus("postRst0",   CMD_AUTH,     2'd0, 16'h1234, 20'd0,    ST_OK,           20'd1000, 1'b1, 0);
        applyStimulus("postRst1",   CMD_AUTH,     2'd1, 16'h1235, 20'd0,    ST_OK,           20'd1000, 1'b1, 0);
        applyStimulus("postRst2",   CMD_AUTH,     2'd2, 16'h1236, 20'd0,    ST_OK,           20'd1000, 1'b1, 0);

        checkValue("scoreboardEmpty", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
